// File: rtl/svm_window_decision.sv
// svm_window_decision: bias add with saturation, threshold decision,
// coordinate tagging and detection FIFO for the sliding-window SVM pipeline.
module svm_window_decision #(
   parameter int SWIDTH = 32,
   parameter int WPI    = 40,
   parameter int WPF    = 30,
   parameter int FDEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       frame_start,
   input  logic                       score_valid,
   input  logic signed [SWIDTH-1:0]   score_in,
   input  logic signed [SWIDTH-1:0]   bias,
   input  logic signed [SWIDTH-1:0]   threshold,
   input  logic                       det_ready,
   output logic                       det_valid,
   output logic [$clog2(WPI)-1:0]     det_x,
   output logic [$clog2(WPF)-1:0]     det_y,
   output logic signed [SWIDTH-1:0]   det_margin,
   output logic [15:0]                det_count,
   output logic                       overflow,
   output logic                       frame_done,
   output logic                       busy
);

   localparam int XW = $clog2(WPI);
   localparam int YW = $clog2(WPF);
   localparam int AW = $clog2(FDEPTH);
   localparam int CW = AW + 1;
   localparam logic [XW-1:0] XMAX = XW'(WPI - 1);
   localparam logic [YW-1:0] YMAX = YW'(WPF - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                    state_q, state_d;
   logic [XW-1:0]             x_q, x_d;
   logic [YW-1:0]             y_q, y_d;
   logic                      s1_valid_q, s1_valid_d;
   logic [XW-1:0]             s1_x_q, s1_x_d;
   logic [YW-1:0]             s1_y_q, s1_y_d;
   logic signed [SWIDTH-1:0]  s1_margin_q, s1_margin_d;
   logic [15:0]               det_count_q, det_count_d;
   logic                      overflow_q, overflow_d;
   logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             fcnt_q, fcnt_d;
   logic [XW-1:0]             mem_x_q [FDEPTH];
   logic [XW-1:0]             mem_x_d [FDEPTH];
   logic [YW-1:0]             mem_y_q [FDEPTH];
   logic [YW-1:0]             mem_y_d [FDEPTH];
   logic [SWIDTH-1:0]         mem_m_q [FDEPTH];
   logic [SWIDTH-1:0]         mem_m_d [FDEPTH];

   logic                      restart;
   logic                      accept;
   logic                      last_win;
   logic                      empty;
   logic                      full;
   logic                      pop;
   logic                      push_req;
   logic                      push_ok;
   logic                      drop;
   logic signed [SWIDTH:0]    sum;
   logic signed [SWIDTH-1:0]  sat;

   // Handshake and control qualifiers shared by every process below.
   always_comb begin
      restart  = frame_start && (state_q != IDLE);
      accept   = score_valid && (state_q == RUN) && !frame_start;
      last_win = (x_q == XMAX) && (y_q == YMAX);
      empty    = (fcnt_q == '0);
      full     = (fcnt_q == CW'(FDEPTH));
      pop      = !empty && det_ready;
      push_req = s1_valid_q && (s1_margin_q > threshold);
      push_ok  = push_req && (!full || pop);
      drop     = push_req && full && !pop;
   end

   // Bias add one bit wider than the operands, then clamp to range.
   always_comb begin
      sum = {score_in[SWIDTH-1], score_in} + {bias[SWIDTH-1], bias};
      sat = sum[SWIDTH-1:0];
      if (sum[SWIDTH] != sum[SWIDTH-1]) begin
         sat = sum[SWIDTH] ? {1'b1, {(SWIDTH-1){1'b0}}}
                           : {1'b0, {(SWIDTH-1){1'b1}}};
      end
   end

   // Frame FSM; frame_done marks the FLUSH to IDLE hand-back.
   always_comb begin
      state_d    = state_q;
      frame_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_start) state_d = RUN;
         end
         RUN: begin
            if (frame_start) state_d = RUN;
            else if (accept && last_win) state_d = FLUSH;
         end
         FLUSH: begin
            if (frame_start) begin
               state_d = RUN;
            end else if (empty && !s1_valid_q) begin
               state_d    = IDLE;
               frame_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Raster position, stage-1 capture and per-frame status.
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      s1_valid_d  = accept;
      s1_x_d      = s1_x_q;
      s1_y_d      = s1_y_q;
      s1_margin_d = s1_margin_q;
      det_count_d = det_count_q;
      overflow_d  = overflow_q;
      if (frame_start) begin
         x_d         = '0;
         y_d         = '0;
         det_count_d = '0;
         overflow_d  = 1'b0;
      end else begin
         if (accept) begin
            s1_x_d      = x_q;
            s1_y_d      = y_q;
            s1_margin_d = sat;
            if (x_q == XMAX) begin
               x_d = '0;
               y_d = (y_q == YMAX) ? '0 : y_q + 1'b1;
            end else begin
               x_d = x_q + 1'b1;
            end
         end
         if (push_ok && (det_count_q != 16'hFFFF))
            det_count_d = det_count_q + 16'd1;
         if (drop) overflow_d = 1'b1;
      end
   end

   // Detection FIFO; a restart discards everything queued.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fcnt_d   = fcnt_q;
      mem_x_d  = mem_x_q;
      mem_y_d  = mem_y_q;
      mem_m_d  = mem_m_q;
      if (restart) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fcnt_d   = '0;
      end else begin
         if (push_ok) begin
            mem_x_d[wr_ptr_q] = s1_x_q;
            mem_y_d[wr_ptr_q] = s1_y_q;
            mem_m_d[wr_ptr_q] = s1_margin_q;
            wr_ptr_d          = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         fcnt_d = fcnt_q + CW'(push_ok) - CW'(pop);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         s1_valid_q  <= 1'b0;
         s1_x_q      <= '0;
         s1_y_q      <= '0;
         s1_margin_q <= '0;
         det_count_q <= '0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fcnt_q      <= '0;
         for (int i = 0; i < FDEPTH; i++) begin
            mem_x_q[i] <= '0;
            mem_y_q[i] <= '0;
            mem_m_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         s1_valid_q  <= s1_valid_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         s1_margin_q <= s1_margin_d;
         det_count_q <= det_count_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fcnt_q      <= fcnt_d;
         mem_x_q     <= mem_x_d;
         mem_y_q     <= mem_y_d;
         mem_m_q     <= mem_m_d;
      end
   end

   assign det_valid  = !empty;
   assign det_x      = mem_x_q[rd_ptr_q];
   assign det_y      = mem_y_q[rd_ptr_q];
   assign det_margin = mem_m_q[rd_ptr_q];
   assign det_count  = det_count_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_svm_window_decision.sv
// tb_svm_window_decision: directed frames on a 4x2 window grid with
// a 4-deep FIFO, checked against hand-computed detections.
module tb_svm_window_decision;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        frame_start;
   logic        score_valid;
   logic [31:0] score_in;
   logic [31:0] bias;
   logic [31:0] threshold;
   logic        det_ready;
   logic        det_valid;
   logic [1:0]  det_x;
   logic [0:0]  det_y;
   logic [31:0] det_margin;
   logic [15:0] det_count;
   logic        overflow;
   logic        frame_done;
   logic        busy;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;
   int fd_cnt   = 0;

   logic [1:0]  qx [$];
   logic        qy [$];
   logic [31:0] qm [$];
   logic [31:0] sc [8];
   logic [1:0]  ex [8];
   logic        ey [8];
   logic [31:0] em [8];

   svm_window_decision #(
      .SWIDTH(32), .WPI(4), .WPF(2), .FDEPTH(4)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .frame_start(frame_start), .score_valid(score_valid),
      .score_in(score_in), .bias(bias), .threshold(threshold),
      .det_ready(det_ready), .det_valid(det_valid),
      .det_x(det_x), .det_y(det_y), .det_margin(det_margin),
      .det_count(det_count), .overflow(overflow),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Record every accepted pop and every frame_done pulse.
   always @(negedge clk) begin
      if (det_valid && det_ready) begin
         qx.push_back(det_x);
         qy.push_back(det_y[0]);
         qm.push_back(det_margin);
      end
      if (frame_done) fd_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      qx.delete();
      qy.delete();
      qm.delete();
      fd_cnt = 0;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic feed();
      for (int i = 0; i < 8; i++) begin
         score_valid = 1'b1;
         score_in    = sc[i];
         step();
      end
      score_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (fd_cnt == 0 && n < 40) begin
         step();
         n++;
      end
      step();
      step();
      check({tag, "_done_once"}, fd_cnt, 1);
   endtask

   task automatic check_q(input string tag, input int n);
      check({tag, "_ndet"}, qx.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < qx.size())
            check($sformatf("%s_det%0d", tag, i),
                  {qx[i], qy[i], qm[i]}, {ex[i], ey[i], em[i]});
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      frame_start = 1'b0;
      score_valid = 1'b0;
      score_in    = '0;
      bias        = '0;
      threshold   = '0;
      det_ready   = 1'b1;
      step();
      step();
      check("rst_valid", det_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_count", det_count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_done", frame_done, 0);
      reset_n = 1'b1;
      step();

      // Scores before any frame are ignored.
      score_valid = 1'b1;
      score_in    = 32'd100;
      step();
      score_valid = 1'b0;
      step();
      step();
      step();
      check("pre_valid", det_valid, 0);
      check("pre_busy", busy, 0);
      check("pre_count", det_count, 0);

      // Frame 1: every window scores 1.
      clear_q();
      for (int i = 0; i < 8; i++) begin
         sc[i] = 32'd1;
         ex[i] = 2'(i % 4);
         ey[i] = 1'(i / 4);
         em[i] = 32'd1;
      end
      start_frame();
      check("f1_busy", busy, 1);
      feed();
      wait_done("f1");
      check_q("f1", 8);
      check("f1_count", det_count, 8);
      check("f1_ovf", overflow, 0);
      check("f1_idle", busy, 0);

      // Positive saturation.
      clear_q();
      bias = 32'h20;
      sc[0] = 32'h7FFFFFF0;
      for (int i = 1; i < 8; i++) sc[i] = 32'hFFFFFFE0;
      ex[0] = 2'd0; ey[0] = 1'b0; em[0] = 32'h7FFFFFFF;
      start_frame();
      feed();
      wait_done("satp");
      check_q("satp", 1);
      check("satp_count", det_count, 1);

      // Negative saturation against the most negative threshold.
      clear_q();
      bias      = 32'hFFFFFFE0;
      threshold = 32'h80000000;
      for (int i = 0; i < 8; i++) sc[i] = 32'h80000010;
      sc[1] = 32'h0;
      ex[0] = 2'd1; ey[0] = 1'b0; em[0] = 32'hFFFFFFE0;
      start_frame();
      feed();
      wait_done("satn");
      check_q("satn", 1);
      check("satn_count", det_count, 1);

      // Strict greater-than at threshold 5.
      clear_q();
      bias      = 32'd0;
      threshold = 32'd5;
      sc[0] = 5; sc[1] = 6; sc[2] = 4; sc[3] = 7;
      sc[4] = 5; sc[5] = 5; sc[6] = 5; sc[7] = 100;
      ex[0] = 2'd1; ey[0] = 1'b0; em[0] = 32'd6;
      ex[1] = 2'd3; ey[1] = 1'b0; em[1] = 32'd7;
      ex[2] = 2'd3; ey[2] = 1'b1; em[2] = 32'd100;
      start_frame();
      feed();
      wait_done("thr");
      check_q("thr", 3);
      check("thr_count", det_count, 3);

      // Overflow with a stalled consumer.
      clear_q();
      threshold = 32'd0;
      det_ready = 1'b0;
      sc[0] = 1; sc[1] = 2; sc[2] = 3; sc[3] = 4;
      sc[4] = 5; sc[5] = 6; sc[6] = 0; sc[7] = 0;
      for (int i = 0; i < 4; i++) begin
         ex[i] = 2'(i);
         ey[i] = 1'b0;
         em[i] = 32'(i + 1);
      end
      start_frame();
      check("ovf_clr", overflow, 0);
      check("ovf_cnt_clr", det_count, 0);
      feed();
      for (int i = 0; i < 5; i++) step();
      check("ovf_flag", overflow, 1);
      check("ovf_count", det_count, 4);
      check("ovf_hold_busy", busy, 1);
      check("ovf_no_done", fd_cnt, 0);
      check("ovf_head", {det_valid, det_x, det_y, det_margin},
            {1'b1, 2'd0, 1'b0, 32'd1});
      det_ready = 1'b1;
      step();
      step();
      step();
      check("ovf_drain3_done", frame_done, 0);
      check("ovf_drain3_valid", det_valid, 1);
      step();
      check("ovf_drain4_valid", det_valid, 0);
      check("ovf_drain4_done", frame_done, 1);
      step();
      check("ovf_after_done", frame_done, 0);
      check("ovf_after_busy", busy, 0);
      check_q("ovf", 4);

      // Restart mid-RUN with two entries queued.
      clear_q();
      det_ready = 1'b0;
      start_frame();
      score_valid = 1'b1;
      score_in    = 32'd1;
      step();
      step();
      score_valid = 1'b0;
      step();
      step();
      check("rs_queued", det_count, 2);
      check("rs_valid_pre", det_valid, 1);
      start_frame();
      check("rs_valid", det_valid, 0);
      check("rs_count", det_count, 0);
      check("rs_busy", busy, 1);
      det_ready   = 1'b1;
      score_valid = 1'b1;
      score_in    = 32'd9;
      step();
      score_valid = 1'b0;
      check("rs_lat1", det_valid, 0);
      step();
      check("rs_lat2", {det_valid, det_x, det_y, det_margin},
            {1'b1, 2'd0, 1'b0, 32'd9});
      for (int i = 0; i < 7; i++) begin
         score_valid = 1'b1;
         score_in    = 32'd0;
         step();
      end
      score_valid = 1'b0;
      wait_done("rs");
      check("rs_count_end", det_count, 1);

      // Asynchronous reset during FLUSH.
      det_ready = 1'b0;
      for (int i = 0; i < 8; i++) sc[i] = 32'd1;
      start_frame();
      feed();
      step();
      step();
      step();
      check("ar_busy_pre", busy, 1);
      check("ar_valid_pre", det_valid, 1);
      fd_cnt  = 0;
      reset_n = 1'b0;
      #1;
      check("ar_valid", det_valid, 0);
      check("ar_busy", busy, 0);
      check("ar_done", frame_done, 0);
      check("ar_count", det_count, 0);
      step();
      step();
      reset_n = 1'b1;
      step();
      step();
      step();
      check("ar_no_done", fd_cnt, 0);
      check("ar_idle", busy, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/svm_window_decision.md
# svm_window_decision

Decision stage directly downstream of the per-slice window accumulator in the sliding-window SVM pipeline. It takes each completed window score, adds the SVM bias with saturation, and compares the result against a programmable threshold. Positive windows are tagged with window coordinates and buffered in a small FIFO for the reporting logic, under a valid/ready handshake. It also brackets frames, reporting a per-frame detection count and overflow status.

## Interface
- SWIDTH, 32, signed score/margin width
- WPI, 40, windows per line (x range 0..WPI-1)
- WPF, 30, window lines per frame (y range 0..WPF-1)
- FDEPTH, 4, detection FIFO depth (power of 2, ≥2)
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  1-cycle pulse, arms a new frame
- score_valid  in  1  1-cycle pulse, score_in holds a completed window score
- score_in  in  SWIDTH  signed window score (raster order, x fastest)
- bias  in  SWIDTH  signed SVM bias, static during a frame
- threshold  in  SWIDTH  signed decision threshold, static during a frame
- det_ready  in  1  consumer accepts detection
- det_valid  out  1  FIFO head valid
- det_x  out  $clog2(WPI)  window column of head
- det_y  out  $clog2(WPF)  window row of head
- det_margin  out  SWIDTH  saturated score+bias of head
- det_count  out  16  detections accepted into FIFO this frame (saturates at 0xFFFF)
- overflow  out  1  sticky: a detection was dropped this frame
- frame_done  out  1  1-cycle pulse, frame complete and FIFO drained
- busy  out  1  high in RUN or FLUSH

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE → RUN on frame_start. Clears x, y, det_count and overflow. FIFO contents are kept.
  - RUN: each score_valid is processed. After the window at (WPI-1, WPF-1) is processed → FLUSH.
  - FLUSH → IDLE once the FIFO is empty, with frame_done pulsed for exactly 1 cycle on that transition.
  - frame_start in RUN or FLUSH restarts the frame: counters cleared, FIFO flushed, no frame_done, stay/enter RUN.
- score_valid in IDLE or FLUSH is ignored and has no effect.
- Stage 1 (registered), on score_valid in RUN:
  - margin = score_in + bias, computed at SWIDTH+1 bits.
  - Clamp to [-2^(SWIDTH-1), 2^(SWIDTH-1)-1].
  - Latch the current x, y alongside the margin.
  - Advance x. On x wrap to 0, advance y.
- Stage 2: if margin > threshold (signed, strict), push {x, y, margin}.
  - If the FIFO is full, drop the entry and set overflow. det_count does not increment.
  - Otherwise push and increment det_count (saturating).
- FIFO: head drives det_*. It pops when det_valid & det_ready. A push and pop in the same cycle while full is accepted, with no drop.
- Reset: all outputs 0, state IDLE, FIFO empty.

## Timing
- Latency from score_valid to det_valid is 2 cycles when the FIFO is empty (stage 1 register, then FIFO write).
- det_x, det_y and det_margin are stable while det_valid & !det_ready.
- Back-to-back score_valid every cycle is supported at full throughput.
- frame_done asserts no earlier than 2 cycles after the last score_valid, and only once the FIFO is empty.
- busy rises 1 cycle after frame_start.
- An asynchronous reset mid-frame clears everything immediately. frame_done is not emitted.

## Test plan
- WPI=4, WPF=2, bias=0, threshold=0. Score 1 at every window, det_ready=1 → 8 detections with (x,y) running (0,0)..(3,1), det_count=8, frame_done once, overflow=0.
- score_in=0x7FFFFFF0, bias=0x20 → det_margin=0x7FFFFFFF. score_in=0x80000010, bias=-0x20 → margin 0x80000000, which is not greater than threshold 0, so there is no detection.
- margin equal to threshold=5 → no push. Margin 6 → push.
- det_ready=0 with FDEPTH=4 and 6 positive windows → 4 buffered, overflow=1, det_count=4. FLUSH holds with no frame_done until det_ready=1 drains 4 entries. frame_done then pulses the cycle after the last pop.
- frame_start mid-RUN with 2 entries queued → FIFO empty, x=y=0, det_count=0, and the next window is reported at (0,0).
- score_valid before the first frame_start → ignored, det_valid stays 0. Asserting reset_n=0 mid-FLUSH → det_valid=0, busy=0, and no frame_done.
